// File: rtl/game_phase_ctrl.sv
// Simon game phase sequencer: one-hot phase enables, settings latch,
// round tracking, player-response timeout and result hold.
module game_phase_ctrl #(
  parameter int ROUND_W       = 6,
  parameter int TIMEOUT_BASE  = 1000,
  parameter int RESULT_CYCLES = 50
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic [1:0]         i_mode,
  input  logic [1:0]         i_level,
  input  logic [1:0]         i_speed,
  input  logic               i_idle_done,
  input  logic               i_show_done,
  input  logic               i_play_done,
  input  logic               i_play_fail,
  output logic               o_idle_en,
  output logic               o_show_en,
  output logic               o_play_en,
  output logic               o_result_en,
  output logic [ROUND_W-1:0] o_round,
  output logic [1:0]         o_mode_q,
  output logic [1:0]         o_level_q,
  output logic [1:0]         o_speed_q,
  output logic               o_win,
  output logic               o_lose,
  output logic [2:0]         o_state
);

  localparam int TW = $clog2(TIMEOUT_BASE + 1);
  localparam int RW = (RESULT_CYCLES > 1) ? $clog2(RESULT_CYCLES) : 1;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_SHOW = 3'd1;
  localparam logic [2:0] S_PLAY = 3'd2;
  localparam logic [2:0] S_NEXT = 3'd3;
  localparam logic [2:0] S_WIN  = 3'd4;
  localparam logic [2:0] S_LOSE = 3'd5;

  logic [2:0]         state;
  logic [TW-1:0]      timer;
  logic [TW-1:0]      limit;
  logic [RW-1:0]      res_cnt;
  logic [ROUND_W-1:0] target;
  logic               timeout;

  always_comb begin
    limit = TW'(TIMEOUT_BASE) >> o_speed_q;
    if (limit == '0) limit = TW'(1);
  end

  assign timeout = (timer == limit - TW'(1));

  always_comb begin
    case (o_level_q)
      2'd0:    target = ROUND_W'(8);
      2'd1:    target = ROUND_W'(16);
      2'd2:    target = ROUND_W'(32);
      default: target = '1;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      timer     <= '0;
      res_cnt   <= '0;
      o_round   <= '0;
      o_mode_q  <= '0;
      o_level_q <= '0;
      o_speed_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_idle_done) begin
            o_mode_q  <= i_mode;
            o_level_q <= i_level;
            o_speed_q <= i_speed;
            o_round   <= ROUND_W'(1);
            state     <= S_SHOW;
          end
        end
        S_SHOW: begin
          if (i_show_done) begin
            timer <= '0;
            state <= S_PLAY;
          end
        end
        S_PLAY: begin
          timer <= timer + TW'(1);
          // Fail (or timeout) outranks a simultaneous done strobe
          if (i_play_fail || timeout)
            state <= o_mode_q[0] ? S_SHOW : S_LOSE;
          else if (i_play_done)
            state <= S_NEXT;
        end
        S_NEXT: begin
          if (o_round == target) begin
            state <= S_WIN;
          end else begin
            o_round <= o_round + ROUND_W'(1);
            state   <= S_SHOW;
          end
        end
        S_WIN, S_LOSE: begin
          if (res_cnt == RW'(RESULT_CYCLES - 1)) begin
            res_cnt <= '0;
            state   <= S_IDLE;
          end else begin
            res_cnt <= res_cnt + RW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // NEXT is bookkeeping for the finished player phase, so play stays enabled
  always_comb begin
    o_idle_en   = 1'b0;
    o_show_en   = 1'b0;
    o_play_en   = 1'b0;
    o_result_en = 1'b0;
    o_win       = 1'b0;
    o_lose      = 1'b0;
    case (state)
      S_SHOW:  o_show_en = 1'b1;
      S_PLAY,
      S_NEXT:  o_play_en = 1'b1;
      S_WIN: begin
        o_result_en = 1'b1;
        o_win       = 1'b1;
      end
      S_LOSE: begin
        o_result_en = 1'b1;
        o_lose      = 1'b1;
      end
      default: o_idle_en = 1'b1;
    endcase
  end

  assign o_state = state;

endmodule

// File: tb/tb_game_phase_ctrl.sv
// Directed bench for game_phase_ctrl: full win, fail/done priority, timeout
// in normal and practice mode, stray strobes, settings hold, mid-game reset.
module tb_game_phase_ctrl;

  logic       clk;
  logic       rst_n;
  logic [1:0] mode, level, speed;
  logic       idle_done, show_done, play_done, play_fail;
  logic       idle_en, show_en, play_en, result_en;
  logic [5:0] round;
  logic [1:0] mode_q, level_q, speed_q;
  logic       win, lose;
  logic [2:0] state;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  game_phase_ctrl #(
    .ROUND_W      (6),
    .TIMEOUT_BASE (1000),
    .RESULT_CYCLES(50)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_mode     (mode),
    .i_level    (level),
    .i_speed    (speed),
    .i_idle_done(idle_done),
    .i_show_done(show_done),
    .i_play_done(play_done),
    .i_play_fail(play_fail),
    .o_idle_en  (idle_en),
    .o_show_en  (show_en),
    .o_play_en  (play_en),
    .o_result_en(result_en),
    .o_round    (round),
    .o_mode_q   (mode_q),
    .o_level_q  (level_q),
    .o_speed_q  (speed_q),
    .o_win      (win),
    .o_lose     (lose),
    .o_state    (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start_game(input logic [1:0] m, input logic [1:0] l, input logic [1:0] s);
    mode = m; level = l; speed = s;
    idle_done = 1'b1; tick(); idle_done = 1'b0;
    chk("start_state", 32'(state), 32'd1);
    chk("start_round", 32'(round), 32'd1);
  endtask

  // Full successful round: SHOW -> PLAY -> NEXT -> SHOW with round+1
  task automatic pass_round(input int unsigned r);
    show_done = 1'b1; tick(); show_done = 1'b0;
    chk("round_play", 32'(state), 32'd2);
    play_done = 1'b1; tick(); play_done = 1'b0;
    chk("round_next", 32'(state), 32'd3);
    tick();
    chk("round_show", 32'(state), 32'd1);
    chk("round_inc", 32'(round), 32'(r + 1));
  endtask

  initial begin
    rst_n = 1'b0; mode = '0; level = '0; speed = '0;
    idle_done = 1'b0; show_done = 1'b0; play_done = 1'b0; play_fail = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // 1. reset state
    chk("rst_idle_en", 32'(idle_en), 32'd1);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_round", 32'(round), 32'd0);
    chk("rst_others", 32'({show_en, play_en, result_en, win, lose}), 32'd0);
    chk("rst_settings", 32'({mode_q, level_q, speed_q}), 32'd0);

    // 5a. stray show_done in IDLE
    show_done = 1'b1; tick(); show_done = 1'b0;
    chk("stray_idle", 32'(state), 32'd0);

    // 2. full win at level 0
    start_game(2'd0, 2'd0, 2'd0);
    chk("show_en", 32'({idle_en, show_en, play_en, result_en}), 32'b0100);
    for (int unsigned r = 1; r < 8; r++) pass_round(r);
    show_done = 1'b1; tick(); show_done = 1'b0;
    play_done = 1'b1; tick(); play_done = 1'b0;
    chk("r8_next", 32'(state), 32'd3);
    tick();
    chk("win_state", 32'(state), 32'd4);
    chk("win_flag", 32'({win, lose, result_en}), 32'b101);
    chk("win_round", 32'(round), 32'd8);
    repeat (49) tick();
    chk("win_hold49", 32'(win), 32'd1);
    tick();
    chk("win_to_idle", 32'(state), 32'd0);
    chk("win_round_held", 32'(round), 32'd8);
    chk("win_off", 32'(win), 32'd0);

    // 3. fail+done at round 3; 5b. level change mid-game, stray show_done in PLAY
    start_game(2'd0, 2'd1, 2'd0);
    level = 2'd3;
    pass_round(1);
    pass_round(2);
    chk("level_held", 32'(level_q), 32'd1);
    show_done = 1'b1; tick();
    chk("r3_play", 32'(state), 32'd2);
    tick(); show_done = 1'b0;
    chk("stray_play", 32'(state), 32'd2);
    play_done = 1'b1; play_fail = 1'b1; tick(); play_done = 1'b0; play_fail = 1'b0;
    chk("fail_prio", 32'(state), 32'd5);
    chk("fail_round", 32'(round), 32'd3);
    chk("lose_flag", 32'({win, lose, result_en}), 32'b011);
    repeat (49) tick();
    chk("lose_hold49", 32'(lose), 32'd1);
    tick();
    chk("lose_to_idle", 32'(state), 32'd0);

    // 4a. timeout, speed 2 -> limit 250, normal mode
    start_game(2'd0, 2'd0, 2'd2);
    chk("speed_q", 32'(speed_q), 32'd2);
    show_done = 1'b1; tick(); show_done = 1'b0;
    chk("to_play", 32'(state), 32'd2);
    repeat (249) tick();
    chk("to_249", 32'(state), 32'd2);
    tick();
    chk("to_lose", 32'(state), 32'd5);
    repeat (50) tick();
    chk("to_idle", 32'(state), 32'd0);

    // 4b. timeout in practice mode replays the round
    start_game(2'd1, 2'd0, 2'd2);
    show_done = 1'b1; tick(); show_done = 1'b0;
    repeat (249) tick();
    chk("pr_249", 32'(state), 32'd2);
    tick();
    chk("pr_show", 32'(state), 32'd1);
    chk("pr_round", 32'(round), 32'd1);

    // 6. reset mid-game in PLAY at round 5
    pass_round(1);
    pass_round(2);
    pass_round(3);
    pass_round(4);
    show_done = 1'b1; tick(); show_done = 1'b0;
    chk("r5_play", 32'(state), 32'd2);
    chk("r5_round", 32'(round), 32'd5);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'd0);
    chk("arst_round", 32'(round), 32'd0);
    chk("arst_en", 32'({idle_en, show_en, play_en, result_en}), 32'b1000);
    chk("arst_mode", 32'(mode_q), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst", 32'(state), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
